// File: rtl/pc_predict_if.sv
// pc_predict_if
//    Bundles the front-end signals exchanged between the PC/prediction unit
//    and the fetch, decode and execute stages.
//    slave  : the pc_predict_unit side (consumes stage inputs, drives pc,
//             prediction, flush/kill and performance counters)
//    master : the pipeline/environment side
//    Signals:
//       stall                  hold the fetch PC
//       pc                     current fetch PC
//       dec_valid/kind/pc/pcimm  decode-stage instruction for prediction
//       pred_taken             combinational decode prediction
//       ex_valid/kind/flag/pc/pcimm/pcjalr/pred_taken  execute resolution
//       flush                  kill fetch + decode (execute redirect)
//       dec_kill               kill fetch only (decode redirect)
//       br_count, mp_count     saturating branch / mispredict counters
interface pc_predict_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             stall;
   logic [XLEN-1:0]  pc;

   logic             dec_valid;
   logic [1:0]       dec_kind;
   logic [XLEN-1:0]  dec_pc;
   logic [XLEN-1:0]  dec_pcimm;
   logic             pred_taken;

   logic             ex_valid;
   logic [1:0]       ex_kind;
   logic             ex_flag;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_pcimm;
   logic [XLEN-1:0]  ex_pcjalr;
   logic             ex_pred_taken;

   logic             flush;
   logic             dec_kill;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mp_count;

   modport master (
      output stall,
      output dec_valid, dec_kind, dec_pc, dec_pcimm,
      output ex_valid, ex_kind, ex_flag, ex_pc, ex_pcimm, ex_pcjalr, ex_pred_taken,
      input  pc, pred_taken, flush, dec_kill, br_count, mp_count
   );

   modport slave (
      input  stall,
      input  dec_valid, dec_kind, dec_pc, dec_pcimm,
      input  ex_valid, ex_kind, ex_flag, ex_pc, ex_pcimm, ex_pcjalr, ex_pred_taken,
      output pc, pred_taken, flush, dec_kill, br_count, mp_count
   );
endinterface

// File: rtl/pc_predict_unit.sv
// pc_predict_unit
//    Fetch PC register with a 2-bit saturating-counter branch history table.
//    Decode asks for a zero-latency prediction; execute resolves branches,
//    trains the table and redirects fetch on a mispredict or JALR.
//    Ports:
//       clk   clock
//       rstn  synchronous active-low reset
//       bus   pc_predict_if.slave (stage inputs, pc, prediction, flush,
//             dec_kill, br_count, mp_count)
module pc_predict_unit #(
   parameter int              XLEN     = 32,
   parameter int              BHT_BITS = 6,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic          clk,
   input  logic          rstn,
   pc_predict_if.slave   bus
);
   localparam int BHT_N = 1 << BHT_BITS;

   typedef enum logic [1:0] {
      KIND_SEQ  = 2'b00,
      KIND_BR   = 2'b01,
      KIND_JAL  = 2'b10,
      KIND_JALR = 2'b11
   } kind_e;

   logic [XLEN-1:0]     pc_q, pc_d;
   logic [1:0]          bht_q [BHT_N];
   logic [1:0]          bht_d [BHT_N];
   logic [CNT_W-1:0]    br_count_q, br_count_d;
   logic [CNT_W-1:0]    mp_count_q, mp_count_d;

   logic [BHT_BITS-1:0] dec_idx;
   logic [BHT_BITS-1:0] ex_idx;
   logic                pred_taken;
   logic                ex_is_br;
   logic                mispredict;
   logic                flush;
   logic [XLEN-1:0]     target;

   // Word-aligned PCs: drop the two byte-offset bits before indexing.
   assign dec_idx = bus.dec_pc[BHT_BITS+1:2];
   assign ex_idx  = bus.ex_pc[BHT_BITS+1:2];

   always_comb begin
      pred_taken = bus.dec_valid &
                   (((bus.dec_kind == KIND_BR) & bht_q[dec_idx][1]) |
                    (bus.dec_kind == KIND_JAL));

      ex_is_br   = bus.ex_valid & (bus.ex_kind == KIND_BR);
      mispredict = bus.ex_flag != bus.ex_pred_taken;
      flush      = bus.ex_valid &
                   (((bus.ex_kind == KIND_BR) & mispredict) |
                    (bus.ex_kind == KIND_JALR));

      if (bus.ex_kind == KIND_JALR) begin
         target = {bus.ex_pcjalr[XLEN-1:1], 1'b0};
      end else if (bus.ex_flag) begin
         target = bus.ex_pcimm;
      end else begin
         target = bus.ex_pc + XLEN'(4);
      end
   end

   // Next PC: execute redirect beats stall; stall beats decode redirect.
   always_comb begin
      pc_d = pc_q + XLEN'(4);
      if (flush) begin
         pc_d = target;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = bus.dec_pcimm;
      end
   end

   // BHT training is independent of stall; decode sees the pre-update value
   // in the same cycle because the write only lands at the clock edge.
   always_comb begin
      for (int i = 0; i < BHT_N; i++) begin
         bht_d[i] = bht_q[i];
      end
      if (ex_is_br) begin
         if (bus.ex_flag) begin
            if (bht_q[ex_idx] != 2'b11) begin
               bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
            end
         end else begin
            if (bht_q[ex_idx] != 2'b00) begin
               bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
            end
         end
      end
   end

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      br_count_d = br_count_q;
      mp_count_d = mp_count_q;
      if (ex_is_br && (br_count_q != '1)) begin
         br_count_d = br_count_q + CNT_W'(1);
      end
      if (ex_is_br && mispredict && (mp_count_q != '1)) begin
         mp_count_d = mp_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q       <= RESET_PC;
         br_count_q <= '0;
         mp_count_q <= '0;
         for (int i = 0; i < BHT_N; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         pc_q       <= pc_d;
         br_count_q <= br_count_d;
         mp_count_q <= mp_count_d;
         for (int i = 0; i < BHT_N; i++) begin
            bht_q[i] <= bht_d[i];
         end
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pred_taken = pred_taken;
   assign bus.flush      = flush;
   assign bus.dec_kill   = pred_taken & ~bus.stall & ~flush;
   assign bus.br_count   = br_count_q;
   assign bus.mp_count   = mp_count_q;
endmodule
